// File: rtl/dcd_n_scan_if.sv
// Control and select-line bundle for the dcd_n_scan decoder/sequencer.
// The master drives enable, mode and index; the slave returns the registered
// one-hot lines together with the index, busy and wrap status.
interface dcd_n_scan_if #(
  parameter int N = 4
);
  logic               en;
  logic [1:0]         mode;
  logic [N-1:0]       in;
  logic [(1<<N)-1:0]  out;
  logic [N-1:0]       idx;
  logic               busy;
  logic               wrap;

  modport master (output en, mode, in, input out, idx, busy, wrap);
  modport slave  (input en, mode, in, output out, idx, busy, wrap);
endinterface

// File: rtl/dcd_n_scan.sv
// Registered N-to-2^N one-hot decoder with an internal sequencer.
// DIRECT decodes `in` every cycle; SCAN sweeps the lines continuously; SHOT
// sweeps once from the start index up to the last line and then parks in IDLE.
// Each line dwells DWELL cycles in SCAN/SHOT. en=0 freezes everything.
module dcd_n_scan #(
  parameter int N     = 4,
  parameter int DWELL = 4
) (
  input  logic         clk,
  input  logic         rst,
  dcd_n_scan_if.slave  bus
);

  localparam int               LINES      = 1 << N;
  localparam int               DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0]    DWELL_LAST = DW'(DWELL - 1);
  localparam logic [N-1:0]     IDX_LAST   = '1;
  localparam logic [LINES-1:0] LINE0      = LINES'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2,
    SHOT   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    M_OFF    = 2'b00,
    M_DIRECT = 2'b01,
    M_SCAN   = 2'b10,
    M_SHOT   = 2'b11
  } mode_t;

  state_t           state_q, state_d;
  logic [N-1:0]     idx_q, idx_d;
  logic [LINES-1:0] out_q, out_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic             busy_q, busy_d;
  logic             wrap_q, wrap_d;
  // Remembers whether mode was SHOT on the last enabled cycle, so a SHOT
  // only launches on a fresh entry into mode 11 and never retriggers itself.
  logic             shot_req_q, shot_req_d;

  mode_t            mode;
  logic             dwell_done;
  logic             at_last;
  logic             shot_end;
  logic [N-1:0]     idx_inc;

  assign mode       = mode_t'(bus.mode);
  assign dwell_done = (dwell_q == DWELL_LAST);
  assign at_last    = (idx_q == IDX_LAST);
  assign shot_end   = (state_q == SHOT) && dwell_done && at_last;
  assign idx_inc    = idx_q + N'(1);

  // Next-state and next-output computation for all four states.
  always_comb begin
    // NOTE: every target gets a default before any branch, so no path can
    // leave a variable unassigned and infer a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    out_d      = out_q;
    dwell_d    = dwell_q;
    busy_d     = busy_q;
    wrap_d     = 1'b0;
    shot_req_d = shot_req_q;

    if (bus.en) begin
      shot_req_d = (mode == M_SHOT);
      unique case (mode)
        M_OFF: begin
          state_d = IDLE;
          out_d   = '0;
          busy_d  = 1'b0;
          dwell_d = '0;
          // A SHOT ending on the same edge as the abort still reports wrap.
          wrap_d  = shot_end;
        end

        M_DIRECT: begin
          state_d = DIRECT;
          idx_d   = bus.in;
          out_d   = LINE0 << bus.in;
          busy_d  = 1'b0;
          dwell_d = '0;
        end

        M_SCAN: begin
          busy_d = 1'b0;
          if (state_q != SCAN) begin
            state_d = SCAN;
            idx_d   = bus.in;
            out_d   = LINE0 << bus.in;
            dwell_d = '0;
          end else if (dwell_done) begin
            dwell_d = '0;
            idx_d   = idx_inc;
            out_d   = LINE0 << idx_inc;
            wrap_d  = at_last;
          end else begin
            dwell_d = dwell_q + DW'(1);
          end
        end

        M_SHOT: begin
          if (state_q == SHOT) begin
            if (dwell_done && at_last) begin
              // Sequence complete: park on the last index with lines off.
              state_d = IDLE;
              out_d   = '0;
              busy_d  = 1'b0;
              dwell_d = '0;
              wrap_d  = 1'b1;
            end else if (dwell_done) begin
              dwell_d = '0;
              idx_d   = idx_inc;
              out_d   = LINE0 << idx_inc;
            end else begin
              dwell_d = dwell_q + DW'(1);
            end
          end else if (!shot_req_q) begin
            state_d = SHOT;
            idx_d   = bus.in;
            out_d   = LINE0 << bus.in;
            busy_d  = 1'b1;
            dwell_d = '0;
          end else begin
            // Mode still held at 11 after a finished SHOT: stay idle.
            state_d = IDLE;
            out_d   = '0;
            busy_d  = 1'b0;
            dwell_d = '0;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments let every register sample the
    // pre-edge values, independent of statement order.
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      out_q      <= '0;
      dwell_q    <= '0;
      busy_q     <= 1'b0;
      wrap_q     <= 1'b0;
      shot_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      out_q      <= out_d;
      dwell_q    <= dwell_d;
      busy_q     <= busy_d;
      wrap_q     <= wrap_d;
      shot_req_q <= shot_req_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.idx  = idx_q;
  assign bus.busy = busy_q;
  assign bus.wrap = wrap_q;

endmodule

// File: doc/dcd_n_scan.md
Name: dcd_n_scan

Overview:
Parametrised, registered N-to-2^N one-hot decoder. Succeeds the fixed 4-to-16 combinational decoder, adding enable and freeze control plus an internal sequencer. Besides direct decode of `in`, it can sweep the one-hot output across all lines: continuously (scan) or once (single shot). Used for row/LED/chip-select strobing where a select line must dwell a programmable number of cycles.

Parameters:
N, 4, select width; 2^N output lines; legal range 1..8
DWELL, 4, cycles each line stays active in scan/shot modes; legal range >= 1

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  1 = operate; 0 = freeze all state and outputs
mode  input  2  00 OFF, 01 DIRECT, 10 SCAN, 11 SHOT
in  input  N  DIRECT: line to decode; SCAN/SHOT: start index, sampled on mode entry
out  output  2^N  registered one-hot (or all-zero) select lines
idx  output  N  index currently driven on out
busy  output  1  high while the SHOT sequence runs
wrap  output  1  one-cycle pulse when an index step goes from 2^N-1 to 0 (SCAN) or when SHOT finishes

Behaviour:
- Reset (async, rst=1): state=IDLE, out=0, idx=0, busy=0, wrap=0, dwell counter=0. Leaving reset is clean on the next clk edge.
- All outputs are registered. Nothing is combinational from inputs to outputs.
- en=0: state, counters and outputs hold their values. wrap is forced to 0 on that cycle. mode and in are ignored.
- States: IDLE, DIRECT, SCAN, SHOT. Each clock with en=1:
  - mode=00 from any state -> IDLE; out<=0, busy<=0 (aborts a SHOT). idx holds.
  - mode=01 -> DIRECT; idx<=in, out<=1<<in. Latency is 1 cycle and `in` is tracked every cycle.
  - mode=10 entered from a non-SCAN state -> SCAN; idx<=in, out<=1<<in, dwell<=0.
  - In SCAN: dwell increments each cycle. When dwell==DWELL-1: dwell<=0 and idx<=idx+1 mod 2^N; out follows idx.
  - SCAN wrap: on the step 2^N-1 -> 0, wrap=1 for that one cycle.
  - mode=11 entered from a non-SHOT state, and only on the 0->1 transition of (mode==11): -> SHOT; idx<=in, out<=1<<in, busy<=1, dwell<=0.
  - In SHOT: stepping is the same as SCAN. When idx==2^N-1 and dwell==DWELL-1: -> IDLE, out<=0, busy<=0, wrap=1, idx holds 2^N-1.
  - After a SHOT finishes, mode staying at 11 does not retrigger. mode must leave 11 for at least one enabled cycle first.
- Mode change mid-sequence: takes effect on the next edge. The dwell counter and start index are reloaded from `in`; there is no resume.
- DWELL=1: idx advances every cycle.
- N=1: 2 lines. Wrap occurs every 2*DWELL cycles in SCAN when starting from 0.
- Width rules:
  - dwell counter width = max(1, clog2(DWELL)).
  - idx increment is modulo 2^N with no overflow flag other than wrap.
  - out is never more than one-hot.
- Simultaneous events: if the end of a SHOT coincides with mode->00, the IDLE result is the same. wrap=1 is still emitted.

Test Plan:
- Reset: N=4, DWELL=2. Assert rst mid-SCAN at idx=5 asynchronously -> out=0, idx=0, busy=0, wrap=0 immediately, without waiting for a clock edge.
- DIRECT: en=1, mode=01, in=0..15 one per cycle -> each cycle out = 1<<in(previous cycle), e.g. in=9 gives out=16'h0200 on the next edge. in=15 gives 16'h8000.
- SCAN wrap: mode=10, in=14, DWELL=2 -> out=0x4000 for 2 cycles, then 0x8000 for 2 cycles, then 0x0001 with wrap=1 for exactly 1 cycle. Continues 0x0002 and onward.
- SHOT: mode=11, in=13, DWELL=2 -> busy=1 for 6 cycles (idx 13, 14, 15). Then out=0, busy=0, wrap pulse, idx=15. Holding mode=11 produces no retrigger. Toggling mode 00 -> 11 restarts from the current `in`.
- Freeze: mid-SCAN at idx=3, dwell=1, drop en for 5 cycles -> out=0x0008 held and no wrap. On en=1, idx steps to 4 after 1 cycle.
- Abort and parameters: mid-SHOT set mode=00 -> out=0 and busy=0 next edge. Repeat SCAN with DWELL=1 and N=3 -> out steps every cycle; wrap pulses every 8 cycles.
